pilha_parametrizada: RTL and testbench

//   Parametrised LIFO stack. Successor to the fixed 8x8 stack used for call/return addresses.
//   - Width and depth are configurable; top-of-stack is visible without a pop (show-ahead).
//   - Adds push+pop in one cycle (replace top), occupancy count and almost-full.
//   - Adds sticky overflow/underflow error flags and an optional circular-overwrite mode.
//   - Sits between Controle and the datapath; stores PC return addresses or operands.

---
 rtl/pilha_parametrizada.sv | 133 +++++++++++++
 tb/tb_pilha_parametrizada.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pilha_parametrizada.sv
`default_nettype none
// ============================================================================
//  Module   : pilha_parametrizada
//  Purpose  : Parametrised LIFO stack with show-ahead top-of-stack output,
//             same-cycle push+pop (replace top), occupancy count,
//             almost-full flag and sticky overflow/underflow error flags.
//             Sits between the controller and the datapath and holds PC
//             return addresses or operands.
//  Options  : PILHA_WRAP_EN - when defined, a push while full overwrites the
//             oldest entry (circular return-address stack). When undefined,
//             the pushed data is dropped and the stack is left unchanged.
//  Ports    : clk          - clock; all state changes on the rising edge
//             rst_n        - synchronous reset, active low
//             push, pop    - operation select {push,pop}
//             data_in      - data to push or to replace the top with
//             clr_err      - clears the sticky error flags
//             data_out     - current top entry, 0 while empty
//             empty, full  - count == 0 / count == DEPTH
//             almost_full  - count >= AF_LEVEL
//             count        - number of valid entries
//             overflow     - sticky: push while full without a pop
//             underflow    - sticky: pop while empty
//  Revision : 1.0 - initial release
// ============================================================================
module pilha_parametrizada #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       clr_err,
  output logic [DATA_W-1:0]          data_out,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int C_CNT_W = $clog2(DEPTH + 1);
  localparam int C_PTR_W = $clog2(DEPTH);

  localparam logic [C_CNT_W-1:0] C_DEPTH_CNT = C_CNT_W'(DEPTH);
  localparam logic [C_CNT_W-1:0] C_AF_CNT    = C_CNT_W'(AF_LEVEL);

  // Storage is deliberately not reset; validity is tracked by r_count.
  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [C_PTR_W-1:0] r_sp;
  logic [C_CNT_W-1:0] r_count;
  logic               r_overflow;
  logic               r_underflow;

  logic               w_empty;
  logic               w_full;
  logic [C_PTR_W-1:0] w_top_idx;

  // Empty/full come from the count: in wrap mode sp alone cannot tell them apart.
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == C_DEPTH_CNT);
  assign w_top_idx = r_sp - 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sp        <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      // Clear first so an error detected in this cycle overrides it below.
      if (clr_err) begin
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end

      case ({push, pop})
        2'b10: begin
          if (!w_full) begin
            r_mem[r_sp] <= data_in;
            r_sp        <= r_sp + 1'b1;
            r_count     <= r_count + 1'b1;
          end else begin
`ifdef PILHA_WRAP_EN
            // Overwrite the oldest slot; count saturates at DEPTH.
            r_mem[r_sp] <= data_in;
            r_sp        <= r_sp + 1'b1;
`endif
            r_overflow  <= 1'b1;
          end
        end

        2'b01: begin
          if (!w_empty) begin
            r_sp    <= r_sp - 1'b1;
            r_count <= r_count - 1'b1;
          end else begin
            r_underflow <= 1'b1;
          end
        end

        2'b11: begin
          if (!w_empty) begin
            // Replace the top in place; occupancy unchanged, so no overflow even when full.
            r_mem[w_top_idx] <= data_in;
          end else begin
            // Nothing to pop: the push half still goes through.
            r_mem[r_sp] <= data_in;
            r_sp        <= r_sp + 1'b1;
            r_count     <= r_count + 1'b1;
            r_underflow <= 1'b1;
          end
        end

        default: begin
        end
      endcase
    end
  end

  assign data_out    = w_empty ? '0 : r_mem[w_top_idx];
  assign empty       = w_empty;
  assign full        = w_full;
  assign almost_full = (r_count >= C_AF_CNT);
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_pilha_parametrizada.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pilha_parametrizada
//  Purpose  : Self-checking bench for pilha_parametrizada (DATA_W=8, DEPTH=8,
//             AF_LEVEL=7). Vectors hold one cycle of stimulus plus the state
//             expected after that clock edge; expectations are queued when the
//             stimulus is driven and popped when the outputs are sampled.
//             Honours PILHA_WRAP_EN for the full-stack overwrite case.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pilha_parametrizada;

  localparam int C_DATA_W = 8;
  localparam int C_DEPTH  = 8;
  localparam int C_AF     = 7;

  typedef struct {
    logic       rst_n;
    logic       push;
    logic       pop;
    logic       clr;
    logic [7:0] din;
    logic [7:0] dout;
    logic [3:0] cnt;
    logic       empty;
    logic       full;
    logic       af;
    logic       ovf;
    logic       udf;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       push;
  logic       pop;
  logic [7:0] data_in;
  logic       clr_err;
  logic [7:0] data_out;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  vec_t vecs[$];
  vec_t sb[$];
  int   errors = 0;
  int   checks = 0;

  pilha_parametrizada #(
    .DATA_W  (C_DATA_W),
    .DEPTH   (C_DEPTH),
    .AF_LEVEL(C_AF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .data_in    (data_in),
    .clr_err    (clr_err),
    .data_out   (data_out),
    .empty      (empty),
    .full       (full),
    .almost_full(almost_full),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Append one vector; the count-derived flags follow their definitions.
  function automatic void add(input logic r, input logic pu, input logic po,
                              input logic cl, input logic [7:0] di,
                              input logic [7:0] dout, input int cnt,
                              input logic ovf, input logic udf);
    vec_t v;
    v.rst_n = r;  v.push = pu; v.pop = po; v.clr = cl; v.din = di;
    v.dout  = dout;
    v.cnt   = 4'(cnt);
    v.empty = (cnt == 0);
    v.full  = (cnt == C_DEPTH);
    v.af    = (cnt >= C_AF);
    v.ovf   = ovf;
    v.udf   = udf;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int step,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at step %0d: got 0x%0h, expected 0x%0h", name, step, got, exp);
    end
  endtask

  initial begin
    vec_t e;
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; data_in = '0;

    // rst, push, pop, clr, din, dout, count, ovf, udf
    // Reset for two cycles
    add(0,0,0,0,8'h00, 8'h00,0, 0,0);
    add(0,0,0,0,8'h00, 8'h00,0, 0,0);
    // Push 11,22,33 then pop three times
    add(1,1,0,0,8'h11, 8'h11,1, 0,0);
    add(1,1,0,0,8'h22, 8'h22,2, 0,0);
    add(1,1,0,0,8'h33, 8'h33,3, 0,0);
    add(1,0,1,0,8'h00, 8'h22,2, 0,0);
    add(1,0,1,0,8'h00, 8'h11,1, 0,0);
    add(1,0,1,0,8'h00, 8'h00,0, 0,0);
    // Pop on empty, then clear
    add(1,0,1,0,8'h00, 8'h00,0, 0,1);
    add(1,0,0,1,8'h00, 8'h00,0, 0,0);
    // Replace top with push+pop
    add(1,1,0,0,8'h11, 8'h11,1, 0,0);
    add(1,1,0,0,8'h22, 8'h22,2, 0,0);
    add(1,1,1,0,8'h5A, 8'h5A,2, 0,0);
    add(1,0,1,0,8'h00, 8'h11,1, 0,0);
    add(1,0,1,0,8'h00, 8'h00,0, 0,0);
    // push+pop on empty acts as push and flags underflow
    add(1,1,1,0,8'h66, 8'h66,1, 0,1);
    add(1,0,0,1,8'h00, 8'h66,1, 0,0);
    add(1,0,1,0,8'h00, 8'h00,0, 0,0);
    // Error in the same cycle as clr_err: set wins
    add(1,0,1,1,8'h00, 8'h00,0, 0,1);
    add(1,0,0,1,8'h00, 8'h00,0, 0,0);
    // Reset coinciding with a push
    add(1,1,0,0,8'h01, 8'h01,1, 0,0);
    add(1,1,0,0,8'h02, 8'h02,2, 0,0);
    add(1,1,0,0,8'h03, 8'h03,3, 0,0);
    add(0,1,0,0,8'h77, 8'h00,0, 0,0);
    add(1,1,0,0,8'h44, 8'h44,1, 0,0);
    add(1,0,1,0,8'h00, 8'h00,0, 0,0);
    // Fill with 1..8, replace top while full, then push while full
    for (int i = 1; i <= 8; i++) add(1,1,0,0,8'(i), 8'(i),i, 0,0);
    add(1,1,1,0,8'hA8, 8'hA8,8, 0,0);
`ifdef PILHA_WRAP_EN
    add(1,1,0,0,8'h99, 8'h99,8, 1,0);
    add(1,0,1,0,8'h00, 8'hA8,7, 1,0);
    for (int i = 6; i >= 1; i--) add(1,0,1,0,8'h00, 8'(i+1),i, 1,0);
    add(1,0,1,0,8'h00, 8'h00,0, 1,0);
`else
    add(1,1,0,0,8'h99, 8'hA8,8, 1,0);
    for (int i = 7; i >= 1; i--) add(1,0,1,0,8'h00, 8'(i),i, 1,0);
    add(1,0,1,0,8'h00, 8'h00,0, 1,0);
`endif
    // One pop too many, then clear both flags
    add(1,0,1,0,8'h00, 8'h00,0, 1,1);
    add(1,0,0,1,8'h00, 8'h00,0, 0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n   = vecs[i].rst_n;
      push    = vecs[i].push;
      pop     = vecs[i].pop;
      clr_err = vecs[i].clr;
      data_in = vecs[i].din;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL scoreboard at step %0d: got empty queue, expected an entry", i);
      end else begin
        e = sb.pop_front();
        chk("data_out",    i, 32'(data_out),    32'(e.dout));
        chk("count",       i, 32'(count),       32'(e.cnt));
        chk("empty",       i, 32'(empty),       32'(e.empty));
        chk("full",        i, 32'(full),        32'(e.full));
        chk("almost_full", i, 32'(almost_full), 32'(e.af));
        chk("overflow",    i, 32'(overflow),    32'(e.ovf));
        chk("underflow",   i, 32'(underflow),   32'(e.udf));
      end
    end

    @(negedge clk);
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
